// File: rtl/commit_sequencer_pkg.sv
// Shared definitions for the commit sequencer: register/RoB widths, sentinel ids
// and the retirement FSM state encoding.
package commit_sequencer_pkg;

  localparam int RoB_WIDTH    = 8;
  localparam int EX_REG_WIDTH = 6;

  // Bit 5 set means "instruction writes no architectural register".
  localparam logic [EX_REG_WIDTH-1:0] NON_REG = 6'b100000;
  // Dependency tag meaning "operand has no pending producer in the RoB".
  localparam logic [RoB_WIDTH:0]      NON_DEP = {1'b1, {RoB_WIDTH{1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ST_WAIT = 2'd1,
    S_RECOVER = 2'd2
  } cs_state_e;

endpackage

// File: rtl/commit_sequencer.sv
// Retires one RoB head per cycle into the RF, sequences store release with the LSB
// and runs mispredict flush/recovery. Optional macro COMMIT_CNT_EN adds CS_commit_cnt.
module commit_sequencer
  import commit_sequencer_pkg::*;
#(
  parameter int FLUSH_HOLD = 2
) (
  input  logic                    Sys_clk,
  input  logic                    Sys_rst,
  input  logic                    Sys_rdy,
  input  logic                    RoBCS_valid,
  input  logic [RoB_WIDTH-1:0]    RoBCS_RoB_index,
  input  logic [EX_REG_WIDTH-1:0] RoBCS_rd,
  input  logic [31:0]             RoBCS_value,
  input  logic                    RoBCS_is_branch,
  input  logic                    RoBCS_pre_judge,
  input  logic                    RoBCS_is_store,
  input  logic [31:0]             RoBCS_target_pc,
  output logic                    CSRoB_ready,
  output logic                    CSRF_en,
  output logic [RoB_WIDTH-1:0]    CSRF_RoB_index,
  output logic [EX_REG_WIDTH-1:0] CSRF_rd,
  output logic [31:0]             CSRF_value,
  output logic                    CSRF_pre_judge,
  output logic                    CSLSB_store_en,
  output logic [RoB_WIDTH-1:0]    CSLSB_RoB_index,
  input  logic                    LSBCS_store_done,
  output logic                    CS_flush,
  output logic                    CSIF_pc_en,
  output logic [31:0]             CSIF_pc,
`ifdef COMMIT_CNT_EN
  output logic [31:0]             CS_commit_cnt,
`endif
  output logic                    CSDP_stall
);

  cs_state_e               state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic                    rf_en_q, rf_en_d;
  logic [RoB_WIDTH-1:0]    rf_idx_q, rf_idx_d;
  logic [EX_REG_WIDTH-1:0] rf_rd_q, rf_rd_d;
  logic [31:0]             rf_val_q, rf_val_d;
  logic                    pre_judge_q, pre_judge_d;
  logic                    st_en_q, st_en_d;
  logic [RoB_WIDTH-1:0]    st_idx_q, st_idx_d;
  logic                    flush_q, flush_d;
  logic                    pc_en_q, pc_en_d;
  logic [31:0]             pc_q, pc_d;
  logic                    stall_q, stall_d;
  logic                    pop;
  logic                    mispredict;
`ifdef COMMIT_CNT_EN
  logic [31:0]             commit_cnt_q, commit_cnt_d;
`endif

  assign CSRoB_ready = (state_q == S_IDLE) & Sys_rdy;
  assign pop         = RoBCS_valid & CSRoB_ready;
  assign mispredict  = RoBCS_is_branch & ~RoBCS_pre_judge;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rf_en_d     = 1'b0;
    rf_idx_d    = rf_idx_q;
    rf_rd_d     = rf_rd_q;
    rf_val_d    = rf_val_q;
    pre_judge_d = 1'b1;
    st_en_d     = 1'b0;
    st_idx_d    = st_idx_q;
    flush_d     = 1'b0;
    pc_en_d     = 1'b0;
    pc_d        = pc_q;
    stall_d     = stall_q;
`ifdef COMMIT_CNT_EN
    commit_cnt_d = pop ? commit_cnt_q + 32'd1 : commit_cnt_q;
`endif

    // With Sys_rdy low every strobe defaults to 0 and all state holds.
    if (Sys_rdy) begin
      case (state_q)
        S_IDLE: begin
          if (pop) begin
            if (mispredict) begin
              // The branch itself still commits (JAL-type rd is written).
              rf_en_d     = 1'b1;
              rf_idx_d    = RoBCS_RoB_index;
              rf_rd_d     = RoBCS_rd;
              rf_val_d    = RoBCS_value;
              pre_judge_d = 1'b0;
              flush_d     = 1'b1;
              pc_en_d     = 1'b1;
              pc_d        = RoBCS_target_pc;
              stall_d     = 1'b1;
              cnt_d       = 4'(FLUSH_HOLD);
              state_d     = S_RECOVER;
            end else if (RoBCS_is_store) begin
              st_en_d  = 1'b1;
              st_idx_d = RoBCS_RoB_index;
              state_d  = S_ST_WAIT;
            end else begin
              rf_en_d  = 1'b1;
              rf_idx_d = RoBCS_RoB_index;
              rf_rd_d  = RoBCS_rd;
              rf_val_d = RoBCS_value;
            end
          end
        end
        S_ST_WAIT: begin
          if (LSBCS_store_done) begin
            state_d = S_IDLE;
          end
        end
        S_RECOVER: begin
          if (cnt_q == 4'd1) begin
            cnt_d   = 4'd0;
            stall_d = 1'b0;
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
`ifdef COMMIT_CNT_EN
    else begin
      commit_cnt_d = commit_cnt_q;
    end
`endif
  end

  always_ff @(posedge Sys_clk or negedge Sys_rst) begin
    if (!Sys_rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      rf_en_q     <= 1'b0;
      rf_idx_q    <= '0;
      rf_rd_q     <= NON_REG;
      rf_val_q    <= 32'd0;
      pre_judge_q <= 1'b1;
      st_en_q     <= 1'b0;
      st_idx_q    <= '0;
      flush_q     <= 1'b0;
      pc_en_q     <= 1'b0;
      pc_q        <= 32'd0;
      stall_q     <= 1'b0;
`ifdef COMMIT_CNT_EN
      commit_cnt_q <= 32'd0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rf_en_q     <= rf_en_d;
      rf_idx_q    <= rf_idx_d;
      rf_rd_q     <= rf_rd_d;
      rf_val_q    <= rf_val_d;
      pre_judge_q <= pre_judge_d;
      st_en_q     <= st_en_d;
      st_idx_q    <= st_idx_d;
      flush_q     <= flush_d;
      pc_en_q     <= pc_en_d;
      pc_q        <= pc_d;
      stall_q     <= stall_d;
`ifdef COMMIT_CNT_EN
      commit_cnt_q <= commit_cnt_d;
`endif
    end
  end

  assign CSRF_en         = rf_en_q;
  assign CSRF_RoB_index  = rf_idx_q;
  assign CSRF_rd         = rf_rd_q;
  assign CSRF_value      = rf_val_q;
  assign CSRF_pre_judge  = pre_judge_q;
  assign CSLSB_store_en  = st_en_q;
  assign CSLSB_RoB_index = st_idx_q;
  assign CS_flush        = flush_q;
  assign CSIF_pc_en      = pc_en_q;
  assign CSIF_pc         = pc_q;
  assign CSDP_stall      = stall_q;
`ifdef COMMIT_CNT_EN
  assign CS_commit_cnt   = commit_cnt_q;
`endif

endmodule

// File: tb/tb_commit_sequencer.sv
// Self-checking bench for commit_sequencer: directed scenarios followed by random
// traffic, all checked against a transaction-level model of retirement.
module tb_commit_sequencer;

  localparam int HOLD = 2;

  logic        clk = 1'b0;
  logic        Sys_rst;
  logic        Sys_rdy;
  logic        RoBCS_valid;
  logic [7:0]  RoBCS_RoB_index;
  logic [5:0]  RoBCS_rd;
  logic [31:0] RoBCS_value;
  logic        RoBCS_is_branch;
  logic        RoBCS_pre_judge;
  logic        RoBCS_is_store;
  logic [31:0] RoBCS_target_pc;
  logic        CSRoB_ready;
  logic        CSRF_en;
  logic [7:0]  CSRF_RoB_index;
  logic [5:0]  CSRF_rd;
  logic [31:0] CSRF_value;
  logic        CSRF_pre_judge;
  logic        CSLSB_store_en;
  logic [7:0]  CSLSB_RoB_index;
  logic        LSBCS_store_done;
  logic        CS_flush;
  logic        CSIF_pc_en;
  logic [31:0] CSIF_pc;
  logic        CSDP_stall;
`ifdef COMMIT_CNT_EN
  logic [31:0] CS_commit_cnt;
`endif

  always #5 clk = ~clk;

  commit_sequencer #(.FLUSH_HOLD(HOLD)) dut (
    .Sys_clk         (clk),
    .Sys_rst         (Sys_rst),
    .Sys_rdy         (Sys_rdy),
    .RoBCS_valid     (RoBCS_valid),
    .RoBCS_RoB_index (RoBCS_RoB_index),
    .RoBCS_rd        (RoBCS_rd),
    .RoBCS_value     (RoBCS_value),
    .RoBCS_is_branch (RoBCS_is_branch),
    .RoBCS_pre_judge (RoBCS_pre_judge),
    .RoBCS_is_store  (RoBCS_is_store),
    .RoBCS_target_pc (RoBCS_target_pc),
    .CSRoB_ready     (CSRoB_ready),
    .CSRF_en         (CSRF_en),
    .CSRF_RoB_index  (CSRF_RoB_index),
    .CSRF_rd         (CSRF_rd),
    .CSRF_value      (CSRF_value),
    .CSRF_pre_judge  (CSRF_pre_judge),
    .CSLSB_store_en  (CSLSB_store_en),
    .CSLSB_RoB_index (CSLSB_RoB_index),
    .LSBCS_store_done(LSBCS_store_done),
    .CS_flush        (CS_flush),
    .CSIF_pc_en      (CSIF_pc_en),
    .CSIF_pc         (CSIF_pc),
`ifdef COMMIT_CNT_EN
    .CS_commit_cnt   (CS_commit_cnt),
`endif
    .CSDP_stall      (CSDP_stall)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: what the outside world should observe after each edge.
  bit          m_rf_en, m_pj, m_st_en, m_flush, m_pc_en, m_stall;
  logic [7:0]  m_rf_idx, m_st_idx;
  logic [5:0]  m_rf_rd;
  logic [31:0] m_rf_val, m_pc, m_cnt;
  bit          m_store_pending;
  int          m_recover_left;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_rf_en = 0; m_pj = 1; m_st_en = 0; m_flush = 0; m_pc_en = 0; m_stall = 0;
    m_rf_idx = 0; m_st_idx = 0; m_rf_rd = 6'h20; m_rf_val = 0; m_pc = 0; m_cnt = 0;
    m_store_pending = 0; m_recover_left = 0;
  endtask

  task automatic check_outputs();
    check_val("rf_en",     32'(CSRF_en),         32'(m_rf_en));
    check_val("rf_idx",    32'(CSRF_RoB_index),  32'(m_rf_idx));
    check_val("rf_rd",     32'(CSRF_rd),         32'(m_rf_rd));
    check_val("rf_value",  CSRF_value,           m_rf_val);
    check_val("pre_judge", 32'(CSRF_pre_judge),  32'(m_pj));
    check_val("store_en",  32'(CSLSB_store_en),  32'(m_st_en));
    check_val("store_idx", 32'(CSLSB_RoB_index), 32'(m_st_idx));
    check_val("flush",     32'(CS_flush),        32'(m_flush));
    check_val("pc_en",     32'(CSIF_pc_en),      32'(m_pc_en));
    check_val("pc",        CSIF_pc,              m_pc);
    check_val("dp_stall",  32'(CSDP_stall),      32'(m_stall));
`ifdef COMMIT_CNT_EN
    check_val("commit_cnt", CS_commit_cnt, m_cnt);
`endif
  endtask

  // kind: 0 plain op, 1 correctly predicted branch, 2 mispredicted branch, 3 store
  task automatic step(input bit v, input int kind, input logic [5:0] rd,
                      input logic [31:0] val, input logic [7:0] idx,
                      input logic [31:0] pc, input bit rdy, input bit done);
    bit exp_ready;
    @(negedge clk);
    check_outputs();
    RoBCS_valid      = v;
    RoBCS_RoB_index  = idx;
    RoBCS_rd         = rd;
    RoBCS_value      = val;
    RoBCS_target_pc  = pc;
    RoBCS_is_branch  = (kind == 1) || (kind == 2);
    RoBCS_is_store   = (kind == 3);
    RoBCS_pre_judge  = (kind == 2) ? 1'b0 : (kind == 1) ? 1'b1 : 1'($urandom_range(0, 1));
    Sys_rdy          = rdy;
    LSBCS_store_done = done;
    #1;
    exp_ready = rdy && !m_store_pending && (m_recover_left == 0);
    check_val("ready", 32'(CSRoB_ready), 32'(exp_ready));
    $display("cycle t=%0t v=%0b kind=%0d idx=%0d rdy=%0b done=%0b ready=%0b",
             $time, v, kind, idx, rdy, done, CSRoB_ready);
    if (rdy) begin
      m_rf_en = 0; m_pj = 1; m_st_en = 0; m_flush = 0; m_pc_en = 0;
      if (m_recover_left > 0) begin
        m_recover_left--;
        if (m_recover_left == 0) m_stall = 0;
      end else if (m_store_pending) begin
        if (done) m_store_pending = 0;
      end else if (v) begin
        m_cnt++;
        if (kind == 3) begin
          m_st_en = 1; m_st_idx = idx; m_store_pending = 1;
        end else begin
          m_rf_en = 1; m_rf_idx = idx; m_rf_rd = rd; m_rf_val = val;
          if (kind == 2) begin
            m_pj = 0; m_flush = 1; m_pc_en = 1; m_pc = pc; m_stall = 1;
            m_recover_left = HOLD;
          end
        end
      end
    end else begin
      m_rf_en = 0; m_pj = 1; m_st_en = 0; m_flush = 0; m_pc_en = 0;
    end
  endtask

  task automatic idle(input bit rdy, input bit done);
    step(0, 0, 6'd0, 32'd0, 8'd0, 32'd0, rdy, done);
  endtask

  // Asynchronous reset between clock edges, checked before any edge can occur.
  task automatic async_reset_check(input string tag);
    @(posedge clk);
    #2;
    RoBCS_valid = 0;
    LSBCS_store_done = 0;
    Sys_rst = 0;
    #1;
    model_reset();
    check_outputs();
    check_val({tag, "_ready"}, 32'(CSRoB_ready), 32'(Sys_rdy));
    $display("async reset (%s) at t=%0t", tag, $time);
    @(posedge clk);
    @(negedge clk);
    Sys_rst = 1;
  endtask

  initial begin
    Sys_rst = 0; Sys_rdy = 0; RoBCS_valid = 0; RoBCS_RoB_index = 0; RoBCS_rd = 0;
    RoBCS_value = 0; RoBCS_is_branch = 0; RoBCS_pre_judge = 1; RoBCS_is_store = 0;
    RoBCS_target_pc = 0; LSBCS_store_done = 0;
    model_reset();
    #6;
    check_outputs();
    check_val("reset_ready", 32'(CSRoB_ready), 32'd0);
    #1;
    Sys_rst = 1;
    Sys_rdy = 1;

    // Three back-to-back plain commits.
    step(1, 0, 6'd1, 32'hA, 8'd1, 32'd0, 1, 0);
    step(1, 0, 6'd2, 32'hB, 8'd2, 32'd0, 1, 0);
    step(1, 0, 6'd3, 32'hC, 8'd3, 32'd0, 1, 0);
    idle(1, 0);

    // Mispredict with recovery hold, then a correct branch.
    step(1, 2, 6'd1, 32'h44, 8'd5, 32'h100, 1, 0);
    for (int i = 0; i < HOLD; i++) step(1, 0, 6'd9, 32'hDEAD, 8'd9, 32'd0, 1, 0);
    step(1, 1, 6'd4, 32'h55, 8'd6, 32'h200, 1, 0);
    idle(1, 0);

    // Store done four cycles after release.
    step(1, 3, 6'd0, 32'd0, 8'd7, 32'd0, 1, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 6'd8, 32'h1, 8'd8, 32'd0, 1, 0);
    step(1, 0, 6'd8, 32'h1, 8'd8, 32'd0, 1, 1);
    idle(1, 0);

    // Store done in the same cycle as store_en.
    step(1, 3, 6'd0, 32'd0, 8'd10, 32'd0, 1, 0);
    idle(1, 1);
    idle(1, 0);

    // Freeze for three cycles mid-wait; done while frozen is not acted on.
    step(1, 3, 6'd0, 32'd0, 8'd11, 32'd0, 1, 0);
    idle(1, 0);
    idle(0, 1);
    idle(0, 0);
    idle(0, 1);
    idle(1, 1);
    idle(1, 0);

    // Async reset in RECOVER and in ST_WAIT.
    step(1, 2, 6'd2, 32'h77, 8'd12, 32'h300, 1, 0);
    async_reset_check("rst_recover");
    idle(1, 0);
    step(1, 3, 6'd0, 32'd0, 8'd13, 32'd0, 1, 0);
    async_reset_check("rst_stwait");
    idle(1, 0);

`ifdef COMMIT_CNT_EN
    // Five pops including one store and one mispredict.
    step(1, 0, 6'd1, 32'h1, 8'd20, 32'd0, 1, 0);
    step(1, 3, 6'd0, 32'd0, 8'd21, 32'd0, 1, 0);
    idle(1, 1);
    step(1, 2, 6'd2, 32'h2, 8'd22, 32'h400, 1, 0);
    for (int i = 0; i < HOLD; i++) idle(1, 0);
    step(1, 0, 6'd3, 32'h3, 8'd23, 32'd0, 1, 0);
    step(1, 1, 6'd4, 32'h4, 8'd24, 32'd0, 1, 0);
    idle(1, 0);
    check_val("commit_cnt_5", CS_commit_cnt, 32'd5);
`endif

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 3) != 0, int'($urandom_range(0, 3)),
           6'($urandom), $urandom, 8'($urandom), $urandom,
           $urandom_range(0, 7) != 0, $urandom_range(0, 3) == 0);
    end
    idle(1, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
